// File: rtl/arith_pkg.sv
// Shared arithmetic-lab definitions: serial FSM state encoding and counter sizing.
package arith_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Counter must be able to hold WIDTH itself, hence the +1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (in_1 - in_2 - b_in), LSB first, one bit per clock.
// start/done handshake; a single full_subtractor cell is reused WIDTH times.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               bor_q, bor_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;

  logic               fs_d;
  logic               fs_bout;
  logic [WIDTH-1:0]   res_shifted;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bor_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Difference bits enter at the MSB so the first (LSB) bit lands in bit 0 after WIDTH shifts.
  assign res_shifted = {fs_d, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    bor_d   = bor_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = in_1;
          b_d     = in_2;
          bor_d   = b_in;
          res_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = res_shifted;
        bor_d = fs_bout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Visible result is only updated here, so diff/b_out hold steady otherwise.
          diff_d  = res_shifted;
          bout_d  = fs_bout;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (start) begin
          a_d     = in_1;
          b_d     = in_2;
          bor_d   = b_in;
          res_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      bor_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      bor_q   <= bor_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy  = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);
  assign diff  = diff_q;
  assign b_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] in_1;
  logic [W-1:0] in_2;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in_1  (in_1),
    .in_2  (in_2),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] exp_d;
    logic         exp_bo;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Issue one start pulse, then wait (bounded) for done; report timing and result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        output logic [W-1:0] d, output logic bo, output bit got_done,
                        output int lat, output int busy_n, output bit pulse_ok);
    @(negedge clk);
    in_1 = a; in_2 = b; b_in = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_n = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    got_done = done;
    d  = diff;
    bo = b_out;
    @(posedge clk); #1;
    pulse_ok = !done && !busy;
  endtask

  vec_t vecs[9];

  initial begin
    logic [W-1:0] d;
    logic         bo;
    bit           got, pok;
    int           lat, bn, cyc, sweep_starts, sweep_dones;
    logic [W:0]   ref_v;
    bit           saw_done;

    vecs[0] = '{4'b0001, 4'b1111, 1'b1, 4'b0001, 1'b1};
    vecs[1] = '{4'b1000, 4'b0100, 1'b1, 4'b0011, 1'b0};
    vecs[2] = '{4'b1111, 4'b0001, 1'b1, 4'b1101, 1'b0};
    vecs[3] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1};
    vecs[4] = '{4'b0011, 4'b0011, 1'b0, 4'b0000, 1'b0};
    vecs[5] = '{4'b0111, 4'b1011, 1'b1, 4'b1011, 1'b1};
    vecs[6] = '{4'b0101, 4'b1101, 1'b0, 4'b1000, 1'b1};
    vecs[7] = '{4'b1010, 4'b0011, 1'b0, 4'b0111, 1'b0};
    vecs[8] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};

    rst = 1'b1; start = 1'b0; in_1 = '0; in_2 = '0; b_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy",  busy,  0);
    chk("reset_done",  done,  0);
    chk("reset_diff",  diff,  0);
    chk("reset_b_out", b_out, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_done", done, 0);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bi, d, bo, got, lat, bn, pok);
      chk($sformatf("vec%0d_done_seen", i), got, 1);
      chk($sformatf("vec%0d_latency", i), lat, W);
      chk($sformatf("vec%0d_busy_cycles", i), bn, W);
      chk($sformatf("vec%0d_single_pulse", i), pok, 1);
      chk($sformatf("vec%0d_diff", i), d, vecs[i].exp_d);
      chk($sformatf("vec%0d_b_out", i), bo, vecs[i].exp_bo);
      // Result must persist through IDLE.
      chk($sformatf("vec%0d_diff_hold", i), diff, vecs[i].exp_d);
    end

    // start held high: one result every W+1 cycles, mid-SHIFT input changes ignored.
    @(negedge clk);
    in_1 = 4'b0101; in_2 = 4'b1101; b_in = 1'b0; start = 1'b1;
    cyc = 0;
    @(posedge clk); #1;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bb_first_done", done, 1);
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      chk($sformatf("bb%0d_restart_busy", r), busy, 1);
      in_1 = 4'b1111; in_2 = 4'b0000; b_in = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      in_1 = 4'b0101; in_2 = 4'b1101; b_in = 1'b0;
      cyc = 3;
      while (!done && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk($sformatf("bb%0d_period", r), cyc, W + 1);
      chk($sformatf("bb%0d_diff", r), diff, 4'b1000);
      chk($sformatf("bb%0d_b_out", r), b_out, 1);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);

    // Asynchronous reset mid-SHIFT, off the clock edge.
    @(negedge clk);
    in_1 = 4'b1010; in_2 = 4'b0011; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy",  busy,  0);
    chk("abort_done",  done,  0);
    chk("abort_diff",  diff,  0);
    chk("abort_b_out", b_out, 0);
    #2;
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    run_op(4'b0111, 4'b1011, 1'b1, d, bo, got, lat, bn, pok);
    chk("post_abort_done", got, 1);
    chk("post_abort_diff", d, 4'b1011);
    chk("post_abort_b_out", bo, 1);

    // Exhaustive sweep against a widened-arithmetic reference.
    sweep_starts = 0;
    sweep_dones  = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int bi = 0; bi < 2; bi++) begin
          ref_v = {1'b0, 4'(a)} - {1'b0, 4'(b)} - 5'(bi);
          sweep_starts++;
          run_op(4'(a), 4'(b), 1'(bi), d, bo, got, lat, bn, pok);
          if (got) sweep_dones++;
          chk($sformatf("sweep_%0d_%0d_%0d", a, b, bi), {27'd0, bo, d}, {27'd0, ref_v[W], ref_v[W-1:0]});
        end
      end
    end
    chk("sweep_done_count", sweep_dones, sweep_starts);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
